// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port and the data port of the core.
// Optional feature macro: SOC_ARB_RR_EN selects round-robin arbitration;
// when undefined the data port has fixed priority over the instruction port.
//
// Handshake: a master raises req with stable fields and holds them until gnt.
// gnt is a one-cycle pulse in the cycle the request is accepted. The fields
// seen in that cycle are latched. The response arrives later as a one-cycle
// rvalid pulse with rdata/err. Only one transaction is outstanding at a time.
module soc_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_AW      = 12,
    parameter int WAIT_STATES = 0,
    localparam int SEL_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [SEL_W-1:0]  d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [SEL_W-1:0]  mem_sel,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic              arb_open;
    logic              grant_i, grant_d;
    logic              i_oor, d_oor;
    logic              own_d_q, we_q, err_q;
    logic [SEL_W-1:0]  sel_q;
    logic [MEM_AW-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] resp_data;
    logic              unused_addr_bits;

    // Byte-offset bits never reach the word-addressed memory.
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    // Any address bit above the memory window marks the access out of range.
    assign i_oor = |i_addr[ADDR_W-1:MEM_AW+2];
    assign d_oor = |d_addr[ADDR_W-1:MEM_AW+2];

    // A new request can only be accepted while idle or while responding.
    assign arb_open = !rst && ((state == ST_IDLE) || (state == ST_RESP));

`ifdef SOC_ARB_RR_EN
    logic last_d;

    // Round-robin choice: on contention, the master not granted last wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (arb_open) begin
            if (d_req && (!i_req || !last_d)) grant_d = 1'b1;
            else if (i_req)                   grant_i = 1'b1;
        end
    end

    // Remember which master took the most recent grant; resets to "instr last".
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      last_d <= 1'b0;
        else if (grant_i || grant_d)  last_d <= grant_d;
    end
`else
    // Fixed priority: the data port always wins on contention.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (arb_open) begin
            if (d_req)      grant_d = 1'b1;
            else if (i_req) grant_i = 1'b1;
        end
    end
`endif

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state logic: one access cycle, WAIT_STATES wait cycles, one response cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = 4'd0;
        case (state)
            ST_IDLE:   if (grant_i || grant_d) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt + 4'd1;
                if (wait_cnt_nxt == WS_CNT) state_nxt = ST_RESP;
            end
            ST_RESP:   state_nxt = (grant_i || grant_d) ? ST_ACCESS : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winning request; instruction fetches are full-word reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_d_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (grant_d) begin
            own_d_q <= 1'b1;
            we_q    <= d_we;
            err_q   <= d_oor;
            sel_q   <= d_sel;
            waddr_q <= d_addr[MEM_AW+1:2];
            wdata_q <= d_wdata;
        end else if (grant_i) begin
            own_d_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= i_oor;
            sel_q   <= '1;
            waddr_q <= i_addr[MEM_AW+1:2];
            wdata_q <= '0;
        end
    end

    // Memory strobe only in the access cycle and never for out-of-range accesses.
    always_comb begin
        mem_ce    = (state == ST_ACCESS) && !err_q;
        mem_we    = mem_ce && we_q;
        mem_sel   = mem_ce ? sel_q   : '0;
        mem_addr  = mem_ce ? waddr_q : '0;
        mem_wdata = mem_ce ? wdata_q : '0;
    end

    // Response: route memory data to the owner; writes and errors return zero.
    always_comb begin
        resp_data = ((state == ST_RESP) && !we_q && !err_q) ? mem_rdata : '0;
        i_rvalid  = (state == ST_RESP) && !own_d_q;
        d_rvalid  = (state == ST_RESP) && own_d_q;
        i_rdata   = i_rvalid ? resp_data : '0;
        d_rdata   = d_rvalid ? resp_data : '0;
        i_err     = i_rvalid && err_q;
        d_err     = d_rvalid && err_q;
    end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Bench for soc_mem_arbiter: directed scenarios with literal expectations,
// then randomized two-master traffic compared every cycle against a
// timing-rule reference model with its own memory image.
module tb_soc_mem_arbiter;

  localparam int WS  = 3;
  localparam int LAT = 2 + WS;

  logic        clk, rst;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_sel;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_ce, mem_we;
  logic [3:0]  mem_sel;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_mem  [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] mem_tmp;

  soc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_AW(12), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish within 2 ms");
    $fatal(1);
  end

  // ---------------- synchronous memory ----------------
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) begin
        mem_tmp = tb_mem[mem_addr];
        for (int b = 0; b < 4; b++)
          if (mem_sel[b]) mem_tmp[8*b +: 8] = mem_wdata[8*b +: 8];
        tb_mem[mem_addr] <= mem_tmp;
      end else begin
        mem_rdata <= tb_mem[mem_addr];
      end
    end
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no DUT event, required one within the cycle bound (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          ce_cyc;
    int          resp_cyc;
    bit          own_d;
    bit          we;
    bit          err;
    logic [3:0]  sel;
    logic [11:0] wa;
    logic [31:0] wdata;
  } txn_t;

  txn_t        pend_q[$];
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          busy_until = 0;
  bit          last_d = 1'b0;

  // Expected outputs follow from timing rules: grant at T, strobe at T+1,
  // response at T+LAT, arbiter free again at T+LAT.
  always @(negedge clk) begin : model_blk
    logic        e_ig, e_dg, e_ce, e_irv, e_drv, e_err;
    logic [31:0] e_rd, addr;
    txn_t        ce_t, rs_t, n;
    e_ig = 0; e_dg = 0; e_ce = 0; e_irv = 0; e_drv = 0; e_err = 0; e_rd = '0;
    ce_t = '{default: 0};
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      busy_until = cyc;
      last_d = 1'b0;
    end else begin
      if (pend_q.size() > 0 && pend_q[0].ce_cyc == cyc && !pend_q[0].err) begin
        e_ce = 1;
        ce_t = pend_q[0];
      end
      if (pend_q.size() > 0 && pend_q[0].resp_cyc == cyc) begin
        rs_t  = pend_q.pop_front();
        e_rd  = exp_q.pop_front();
        e_err = rs_t.err;
        if (rs_t.own_d) e_drv = 1; else e_irv = 1;
      end
      if (cyc >= busy_until && (i_req || d_req)) begin
`ifdef SOC_ARB_RR_EN
        if (i_req && d_req) e_dg = !last_d;
        else                e_dg = d_req;
`else
        e_dg = d_req;
`endif
        e_ig   = !e_dg;
        last_d = e_dg;
        addr     = e_dg ? d_addr : i_addr;
        n.own_d  = e_dg;
        n.we     = e_dg ? d_we : 1'b0;
        n.sel    = e_dg ? d_sel : 4'hf;
        n.wdata  = e_dg ? d_wdata : 32'h0;
        n.err    = (addr[31:14] != 0);
        n.wa     = addr[13:2];
        n.ce_cyc = cyc + 1;
        n.resp_cyc = cyc + LAT;
        if (n.err) exp_q.push_back(32'h0);
        else if (n.we) begin
          for (int b = 0; b < 4; b++)
            if (n.sel[b]) ref_mem[n.wa][8*b +: 8] = n.wdata[8*b +: 8];
          exp_q.push_back(32'h0);
        end else exp_q.push_back(ref_mem[n.wa]);
        pend_q.push_back(n);
        busy_until = cyc + LAT;
      end
    end
    chk("i_gnt", i_gnt, e_ig);
    chk("d_gnt", d_gnt, e_dg);
    chk("mem_ce", mem_ce, e_ce);
    if (e_ce) begin
      chk("mem_we", mem_we, ce_t.we);
      chk("mem_sel", mem_sel, ce_t.sel);
      chk("mem_addr", mem_addr, ce_t.wa);
      if (ce_t.we) chk("mem_wdata", mem_wdata, ce_t.wdata);
    end
    if (rst) begin
      chk("rst_mem_out", {mem_we, mem_sel, mem_addr, mem_wdata}, 0);
    end
    chk("i_rvalid", i_rvalid, e_irv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("i_rdata", i_rdata, e_irv ? e_rd : 32'h0);
    chk("d_rdata", d_rdata, e_drv ? e_rd : 32'h0);
    if (e_irv || rst) chk("i_err", i_err, e_irv & e_err);
    if (e_drv || rst) chk("d_err", d_err, e_drv & e_err);
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic txn(input bit is_d, input bit we, input logic [3:0] sel,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat,
                     output int ce_n, output int ce_lat, output logic [11:0] ce_addr,
                     output int other_rv);
    int b;
    bit got;
    rd = '0; er = 0; lat = 0; ce_n = 0; ce_lat = 0; ce_addr = '0; other_rv = 0;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1; d_we = we; d_sel = sel; d_addr = addr; d_wdata = wd;
    end else begin
      i_req = 1; i_addr = addr;
    end
    got = 0; b = 0;
    while (!got && b < 50) begin
      @(negedge clk); b++;
      got = is_d ? d_gnt : i_gnt;
    end
    @(posedge clk); #1;
    if (is_d) d_req = 0; else i_req = 0;
    if (!got) begin
      tmo("txn_gnt");
      return;
    end
    got = 0;
    while (!got && lat < 40) begin
      @(negedge clk); lat++;
      if (mem_ce) begin ce_n++; ce_lat = lat; ce_addr = mem_addr; end
      if (is_d ? i_rvalid : d_rvalid) other_rv++;
      if (is_d ? d_rvalid : i_rvalid) begin
        got = 1;
        rd = is_d ? d_rdata : i_rdata;
        er = is_d ? d_err : i_err;
      end
    end
    if (!got) tmo("txn_rvalid");
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {23'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
    if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(14, 31));
    return a;
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        er, ig, dg, exp_d;
  logic [11:0] cea;
  int          lat, cen, cel, orv, ng, bnd;
  logic        got_d [0:3];
  int          gcyc  [0:3];

  initial begin
    rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_sel = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0;
    for (int k = 0; k < 4096; k++) begin tb_mem[k] = 0; ref_mem[k] = 0; end
    tb_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    chk("reset_i_gnt", i_gnt, 0);
    chk("reset_d_rvalid", d_rvalid, 0);
    chk("reset_mem_ce", mem_ce, 0);
    @(posedge clk); #1 rst = 0;

    // partial-byte write followed by read-back
    txn(1, 1, 4'b0011, 32'h20, 32'h11223344, rd, er, lat, cen, cel, cea, orv);
    chk("wr_err", er, 0);
    chk("wr_rdata", rd, 0);
    chk("wr_lat", lat, LAT);
    chk("wr_ce_n", cen, 1);
    txn(1, 0, 4'hf, 32'h20, 32'h0, rd, er, lat, cen, cel, cea, orv);
    chk("rd_data", rd, 32'h00003344);
    chk("rd_err", er, 0);

    // instruction fetch latency and strobe placement
    txn(0, 0, 4'hf, 32'h10, 32'h0, rd, er, lat, cen, cel, cea, orv);
    chk("i_data", rd, 32'hDEADBEEF);
    chk("i_lat", lat, LAT);
    chk("i_ce_n", cen, 1);
    chk("i_ce_lat", cel, 1);
    chk("i_ce_addr", cea, 12'd4);

    // both masters held for four transactions
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h10;
    d_req = 1; d_we = 0; d_sel = 4'hf; d_addr = 32'h24; d_wdata = 32'h0;
    ng = 0; bnd = 0;
    while (ng < 4 && bnd < 100) begin
      @(negedge clk); bnd++;
      if (i_gnt || d_gnt) begin got_d[ng] = d_gnt; gcyc[ng] = bnd; ng++; end
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    if (ng < 4) tmo("both_grants");
    else begin
      for (int k = 0; k < 4; k++) begin
`ifdef SOC_ARB_RR_EN
        exp_d = (k % 2 == 0);
`else
        exp_d = 1'b1;
`endif
        chk($sformatf("both_grant%0d_is_d", k), got_d[k], exp_d);
        if (k > 0) chk($sformatf("both_gap%0d", k), gcyc[k] - gcyc[k-1], LAT);
      end
    end
    repeat (LAT + 2) @(negedge clk);

    // out-of-range data read
    txn(1, 0, 4'hf, 32'h0001_0000, 32'h0, rd, er, lat, cen, cel, cea, orv);
    chk("oor_ce_n", cen, 0);
    chk("oor_err", er, 1);
    chk("oor_rdata", rd, 0);
    chk("oor_lat", lat, LAT);

    // reset while a data read sits in the wait phase
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_sel = 4'hf; d_addr = 32'h14;
    bnd = 0;
    do begin @(negedge clk); bnd++; end while (!d_gnt && bnd < 50);
    if (!d_gnt) tmo("rst_test_gnt");
    @(posedge clk); #1 d_req = 0;
    @(posedge clk); #1;
    rst = 1; i_req = 1; i_addr = 32'h10;
    @(negedge clk);
    chk("rst_mid_d_rvalid", d_rvalid, 0);
    chk("rst_mid_mem_ce", mem_ce, 0);
    chk("rst_mid_i_gnt", i_gnt, 0);
    @(posedge clk); #1;
    rst = 0; i_req = 0;
    txn(0, 0, 4'hf, 32'h10, 32'h0, rd, er, lat, cen, cel, cea, orv);
    chk("post_rst_i_data", rd, 32'hDEADBEEF);
    chk("post_rst_i_lat", lat, LAT);
    chk("post_rst_no_d_rvalid", orv, 0);

    // randomized two-master traffic
    @(posedge clk); #1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      ig = i_gnt; dg = d_gnt;
      @(posedge clk); #1;
      if (ig || !i_req) begin
        i_req = ($urandom_range(0, 9) < 6);
        i_addr = rand_addr();
      end
      if (dg || !d_req) begin
        d_req = ($urandom_range(0, 9) < 6);
        d_we = 1'($urandom_range(0, 1));
        d_sel = 4'($urandom_range(0, 15));
        d_addr = rand_addr();
        d_wdata = $urandom;
      end
    end
    i_req = 0; d_req = 0;
    repeat (LAT + 3) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
